// File: rtl/mod_butterfly_pipe.sv
// mod_butterfly_pipe: 5-stage pipelined NTT/INTT butterfly over Z_q.
// mode=0 computes the Cooley-Tukey butterfly, mode=1 the Gentleman-Sande one.
// The modular multiply uses Barrett reduction (constant MU, shift K).
// Optional feature macro: MOD_BFLY_HALF_EN adds a 'half' input that scales
// both GS results by 2^-1 mod Q in the output stage.
module mod_butterfly_pipe #(
  parameter int W     = 12,
  parameter int Q     = 3329,
  parameter int K     = 24,
  parameter int MU    = 5039,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     w,
  input  logic [TAG_W-1:0] tag,
`ifdef MOD_BFLY_HALF_EN
  input  logic             half,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int MUW = $clog2(MU + 1);
  localparam logic [W-1:0]   Q_W  = W'(Q);
  localparam logic [W:0]     Q_W1 = (W+1)'(Q);
  localparam logic [W+1:0]   Q_W2 = (W+2)'(Q);
  localparam logic [MUW-1:0] MU_C = MUW'(MU);

  // The whole pipe moves as one; a stalled output freezes every stage.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- S1: inputs plus GS sum/difference ----------------
  logic [W:0]   sum_ab;
  logic [W-1:0] s_c, d_c;
  assign sum_ab = {1'b0, a} + {1'b0, b};
  assign s_c    = W'((sum_ab >= Q_W1) ? (sum_ab - Q_W1) : sum_ab);
  // a-b wraps modulo 2^W, and adding Q brings it back into [0,Q) exactly
  assign d_c    = (a < b) ? (a - b + Q_W) : (a - b);

  logic             v1_reg, mode1_reg;
  logic [W-1:0]     a1_reg, b1_reg, w1_reg, s1_reg, d1_reg;
  logic [TAG_W-1:0] tag1_reg;
`ifdef MOD_BFLY_HALF_EN
  logic             half1_reg, half2_reg, half3_reg, half4_reg;
`endif

  // S1 register: capture the operation and its GS sum/difference
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg <= 1'b0;
    end else if (advance) begin
      v1_reg    <= in_valid;
      mode1_reg <= mode;
      a1_reg    <= a;
      b1_reg    <= b;
      w1_reg    <= w;
      s1_reg    <= s_c;
      d1_reg    <= d_c;
      tag1_reg  <= tag;
`ifdef MOD_BFLY_HALF_EN
      half1_reg <= half;
`endif
    end
  end

  // ---------------- S2: full product ----------------
  logic [W-1:0]     mcand;
  logic [2*W-1:0]   p_c;
  assign mcand = mode1_reg ? d1_reg : b1_reg;
  assign p_c   = {{W{1'b0}}, mcand} * {{W{1'b0}}, w1_reg};

  logic             v2_reg, mode2_reg;
  logic [W-1:0]     a2_reg, s2_reg;
  logic [2*W-1:0]   p2_reg;
  logic [TAG_W-1:0] tag2_reg;

  // S2 register: product of multiplicand and twiddle
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_reg <= 1'b0;
    end else if (advance) begin
      v2_reg    <= v1_reg;
      mode2_reg <= mode1_reg;
      a2_reg    <= a1_reg;
      s2_reg    <= s1_reg;
      p2_reg    <= p_c;
      tag2_reg  <= tag1_reg;
`ifdef MOD_BFLY_HALF_EN
      half2_reg <= half1_reg;
`endif
    end
  end

  // ---------------- S3: Barrett quotient estimate ----------------
  logic [2*W+MUW-1:0] p_mu;
  logic [W:0]         tq_c;
  assign p_mu = {{MUW{1'b0}}, p2_reg} * {{(2*W){1'b0}}, MU_C};
  assign tq_c = (W+1)'(p_mu >> K);

  logic             v3_reg, mode3_reg;
  logic [W-1:0]     a3_reg, s3_reg;
  logic [W+1:0]     p3_reg;
  logic [W:0]       tq3_reg;
  logic [TAG_W-1:0] tag3_reg;

  // S3 register: quotient estimate; only the low W+2 bits of p are needed
  // afterwards because the remainder is known to be below 3Q
  always_ff @(posedge clk) begin
    if (reset) begin
      v3_reg <= 1'b0;
    end else if (advance) begin
      v3_reg    <= v2_reg;
      mode3_reg <= mode2_reg;
      a3_reg    <= a2_reg;
      s3_reg    <= s2_reg;
      p3_reg    <= p2_reg[W+1:0];
      tq3_reg   <= tq_c;
      tag3_reg  <= tag2_reg;
`ifdef MOD_BFLY_HALF_EN
      half3_reg <= half2_reg;
`endif
    end
  end

  // ---------------- S4: remainder and correction ----------------
  logic [W+1:0] tq_q, r0, r1, r2;
  logic [W-1:0] r_c;
  assign tq_q = {1'b0, tq3_reg} * Q_W2;
  assign r0   = p3_reg - tq_q;
  assign r1   = (r0 >= Q_W2) ? (r0 - Q_W2) : r0;
  assign r2   = (r1 >= Q_W2) ? (r1 - Q_W2) : r1;
  assign r_c  = W'(r2);

  logic             v4_reg, mode4_reg;
  logic [W-1:0]     a4_reg, s4_reg, r4_reg;
  logic [TAG_W-1:0] tag4_reg;

  // S4 register: fully reduced product
  always_ff @(posedge clk) begin
    if (reset) begin
      v4_reg <= 1'b0;
    end else if (advance) begin
      v4_reg    <= v3_reg;
      mode4_reg <= mode3_reg;
      a4_reg    <= a3_reg;
      s4_reg    <= s3_reg;
      r4_reg    <= r_c;
      tag4_reg  <= tag3_reg;
`ifdef MOD_BFLY_HALF_EN
      half4_reg <= half3_reg;
`endif
    end
  end

  // ---------------- S5: final add/sub and output register ----------------
  logic [W:0]   sum_ar;
  logic [W-1:0] ct_a, ct_b, res_a, res_b;
  assign sum_ar = {1'b0, a4_reg} + {1'b0, r4_reg};
  assign ct_a   = W'((sum_ar >= Q_W1) ? (sum_ar - Q_W1) : sum_ar);
  assign ct_b   = (a4_reg >= r4_reg) ? (a4_reg - r4_reg) : (a4_reg - r4_reg + Q_W);

`ifdef MOD_BFLY_HALF_EN
  // multiply by 2^-1 mod Q: an odd value is made even by adding Q first
  function automatic logic [W-1:0] halve(input logic [W-1:0] x);
    logic [W:0] t;
    t = {1'b0, x} + (x[0] ? Q_W1 : {(W+1){1'b0}});
    return W'(t >> 1);
  endfunction
  assign res_a = !mode4_reg ? ct_a : (half4_reg ? halve(s4_reg) : s4_reg);
  assign res_b = !mode4_reg ? ct_b : (half4_reg ? halve(r4_reg) : r4_reg);
`else
  assign res_a = mode4_reg ? s4_reg : ct_a;
  assign res_b = mode4_reg ? r4_reg : ct_b;
`endif

  // S5 register: results are held while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      tag_out   <= '0;
    end else if (advance) begin
      out_valid <= v4_reg;
      a_out     <= res_a;
      b_out     <= res_b;
      tag_out   <= tag4_reg;
    end
  end

endmodule

// File: tb/tb_mod_butterfly_pipe.sv
// tb_mod_butterfly_pipe: scoreboard bench for mod_butterfly_pipe.
// The driver pushes hand-computed results when an operation is accepted; a
// monitor pops and compares each result the DUT hands over.
// Build with MOD_BFLY_HALF_EN defined to exercise the 'half' input as well.
module tb_mod_butterfly_pipe;

  localparam int W = 12;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, mode;
  logic [W-1:0]     a, b, w;
  logic [TAG_W-1:0] tag;
  logic             out_valid, out_ready;
  logic [W-1:0]     a_out, b_out;
  logic [TAG_W-1:0] tag_out;
`ifdef MOD_BFLY_HALF_EN
  logic             half;
`endif

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     ea;
    logic [W-1:0]     eb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  mod_butterfly_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .w(w), .tag(tag),
`ifdef MOD_BFLY_HALF_EN
    .half(half),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Present one operation and wait (bounded) for it to be accepted.
  // Returns #1 after the accepting edge with in_valid still high.
  task automatic issue(input logic m, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] iw, input logic [TAG_W-1:0] it,
                       input logic [W-1:0] ea, input logic [W-1:0] eb);
    exp_t e;
    mode = m; a = ia; b = ib; w = iw; tag = it; in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.tag = it; e.ea = ea; e.eb = eb;
        sb.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    @(posedge clk); #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every handed-over result must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got tag=%0d a_out=%0d b_out=%0d, want no output",
                 tag_out, a_out, b_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (tag_out !== e.tag || a_out !== e.ea || b_out !== e.eb) begin
          n_bad++;
          $display("FAIL sb_out: got tag=%0d a_out=%0d b_out=%0d, want tag=%0d a_out=%0d b_out=%0d",
                   tag_out, a_out, b_out, e.tag, e.ea, e.eb);
        end else begin
          $display("out tag=%0d a_out=%0d b_out=%0d ok", tag_out, a_out, b_out);
        end
      end
    end
  end

  // Stall watcher: outputs frozen and in_ready low while the consumer stalls.
  logic             prev_stall = 1'b0;
  logic [W-1:0]     hold_a, hold_b;
  logic [TAG_W-1:0] hold_t;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {31'd0, out_valid, tag_out, a_out, b_out},
              {31'd0, 1'b1, hold_t, hold_a, hold_b});
      if (out_valid && !out_ready)
        check("stall_in_ready", 64'(in_ready), 64'd0);
      prev_stall = out_valid && !out_ready;
      hold_a = a_out; hold_b = b_out; hold_t = tag_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int bp_ea[8] = '{6, 16, 26, 36, 46, 56, 66, 76};
  int bp_eb[8] = '{3323, 4, 14, 24, 34, 44, 54, 64};

  initial begin
    int lat;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    mode = 1'b0; a = '0; b = '0; w = '0; tag = '0;
`ifdef MOD_BFLY_HALF_EN
    half = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_a_out", 64'(a_out), 64'd0);
    check("rst_b_out", 64'(b_out), 64'd0);
    check("rst_tag_out", 64'(tag_out), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Directed vectors, back to back
    issue(1'b0, 12'd100,  12'd200,  12'd17,   8'd1, 12'd171,  12'd29);
    issue(1'b1, 12'd100,  12'd200,  12'd17,   8'd2, 12'd300,  12'd1629);
    issue(1'b0, 12'd3328, 12'd3328, 12'd3328, 8'd3, 12'd0,    12'd3327);
    issue(1'b0, 12'd0,    12'd0,    12'd0,    8'd4, 12'd0,    12'd0);
    issue(1'b1, 12'd3328, 12'd3328, 12'd3328, 8'd5, 12'd3327, 12'd0);
    issue(1'b1, 12'd0,    12'd1,    12'd1,    8'd6, 12'd1,    12'd3328);
    in_valid = 1'b0;
    // With bubbles in between
    @(posedge clk); #1;
    issue(1'b0, 12'd0,    12'd1,    12'd1,    8'd7, 12'd1,    12'd3328);
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    issue(1'b0, 12'd1000, 12'd2,    12'd1700, 8'd8, 12'd1071, 12'd929);
    issue(1'b1, 12'd200,  12'd100,  12'd2,    8'd9, 12'd300,  12'd200);
    issue(1'b0, 12'd5,    12'd1,    12'd1,    8'd10, 12'd6,   12'd4);
    in_valid = 1'b0;
    drain();

    // Back-pressure: 8 streamed ops, consumer stalls for 4 cycles
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue(1'b0, 12'(10 * i), 12'd2, 12'd3, 8'(i), 12'(bp_ea[i]), 12'(bp_eb[i]));
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight
    issue(1'b0, 12'd1, 12'd1, 12'd1, 8'hA0, 12'd2, 12'd0);
    issue(1'b0, 12'd2, 12'd1, 12'd1, 8'hA1, 12'd3, 12'd1);
    issue(1'b0, 12'd3, 12'd1, 12'd1, 8'hA2, 12'd4, 12'd2);
    in_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_a_out", 64'(a_out), 64'd0);
    check("midrst_b_out", 64'(b_out), 64'd0);
    check("midrst_tag_out", 64'(tag_out), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(1'b1, 12'd100, 12'd200, 12'd17, 8'hB0, 12'd300, 12'd1629);
    in_valid = 1'b0;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency_after_reset", 64'(lat), 64'd5);
    drain();
    repeat (10) @(posedge clk); #1;

`ifdef MOD_BFLY_HALF_EN
    half = 1'b1;
    issue(1'b1, 12'd1,   12'd0,   12'd1,  8'd20, 12'd1665, 12'd1665);
    half = 1'b0;
    issue(1'b1, 12'd1,   12'd0,   12'd1,  8'd21, 12'd1,    12'd1);
    half = 1'b1;
    issue(1'b0, 12'd100, 12'd200, 12'd17, 8'd22, 12'd171,  12'd29);
    half = 1'b1;
    issue(1'b1, 12'd100, 12'd200, 12'd17, 8'd23, 12'd150,  12'd2479);
    half = 1'b0;
    in_valid = 1'b0;
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
